// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: op codes, memory access sizes,
// FSM state encoding and the byte-lane mask helper.
package exe_pkg;

    // ALU op codes
    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_AND  = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_XOR  = 6'h04;
    localparam logic [5:0] OP_SLL  = 6'h05;
    localparam logic [5:0] OP_SRL  = 6'h06;
    localparam logic [5:0] OP_SRA  = 6'h07;
    localparam logic [5:0] OP_SLT  = 6'h08;
    localparam logic [5:0] OP_SLTU = 6'h09;

    // MDU op codes; the low three bits select the operation inside exe_mdu
    localparam logic [5:0] OP_MUL    = 6'h20;
    localparam logic [5:0] OP_MULH   = 6'h21;
    localparam logic [5:0] OP_MULHSU = 6'h22;
    localparam logic [5:0] OP_MULHU  = 6'h23;
    localparam logic [5:0] OP_DIV    = 6'h24;
    localparam logic [5:0] OP_DIVU   = 6'h25;
    localparam logic [5:0] OP_REM    = 6'h26;
    localparam logic [5:0] OP_REMU   = 6'h27;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD} mem_size_e;

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_MDU_BUSY} exe_state_e;

    function automatic logic is_mdu_op(input logic [5:0] op);
        return op[5:3] == 3'b100;
    endfunction

    // Unshifted byte-lane mask for an access of 2**size bytes.
    function automatic logic [7:0] size_mask(input logic [1:0] size, input int xlen);
        logic [8:0] m;
        m = (9'd1 << (4'd1 << size)) - 9'd1;
        if (xlen == 32) m[8:4] = '0;
        return m[7:0];
    endfunction

endpackage

// File: rtl/exe_alu.sv
// Combinational ALU.
//   op_i  : op code (non-ALU codes produce 0)
//   a_i   : operand 1, b_i : operand 2
//   y_o   : result
module exe_alu
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [5:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] y_o
);
    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] sh;
    assign sh = b_i[SH_W-1:0];

    always_comb begin
        y_o = '0;
        case (op_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_SLL:  y_o = a_i << sh;
            OP_SRL:  y_o = a_i >> sh;
            OP_SRA:  y_o = $unsigned($signed(a_i) >>> sh);
            OP_SLT:  y_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            OP_SLTU: y_o = {{(XLEN-1){1'b0}}, a_i < b_i};
            default: y_o = '0;
        endcase
    end
endmodule

// File: rtl/exe_mdu.sv
// Iterative multiply/divide unit.
//   start_i  : load operands and begin (one-cycle pulse)
//   abort_i  : drop the running operation
//   op_i     : op_code[2:0] (mul, mulh, mulhsu, mulhu, div, divu, rem, remu)
//   a_i, b_i : operands, sampled on start_i
//   done_o   : high in the last busy cycle; result_o is valid from the next cycle
//   result_o : sign-corrected result, stable until the next start
// Operands are converted to magnitudes on start; the sign is re-applied
// combinationally on the output. Divide-by-zero and signed overflow skip
// the iteration and finish in a single busy cycle.
module exe_mdu
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CNT_W = $clog2(XLEN + 1);

    logic              busy_q, neg_q, special_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   hi_q, lo_q, b_q, spec_res_q;

    // operand preparation
    logic            a_signed, b_signed, a_neg, b_neg, is_div, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, spec_res;

    assign a_signed = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    assign b_signed = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    assign a_neg    = a_signed && a_i[XLEN-1];
    assign b_neg    = b_signed && b_i[XLEN-1];
    assign a_mag    = a_neg ? -a_i : a_i;
    assign b_mag    = b_neg ? -b_i : b_i;
    assign is_div   = op_i[2];
    assign div_zero = is_div && (b_i == '0);
    assign div_ovf  = is_div && !op_i[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
    assign spec_res = div_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);

    // one iteration step
    logic [XLEN:0] mul_sum, div_sh, div_diff;
    logic          div_ok;

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_sh   = {hi_q, lo_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign div_ok   = !div_diff[XLEN];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q     <= 1'b0;
            neg_q      <= 1'b0;
            special_q  <= 1'b0;
            cnt_q      <= '0;
            op_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            b_q        <= '0;
            spec_res_q <= '0;
        end else if (abort_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            busy_q     <= 1'b1;
            op_q       <= op_i;
            // remainder takes the dividend's sign, everything else the xor
            neg_q      <= (is_div && op_i[1]) ? a_neg : (a_neg ^ b_neg);
            special_q  <= div_zero || div_ovf;
            spec_res_q <= spec_res;
            cnt_q      <= (div_zero || div_ovf) ? CNT_W'(1) : CNT_W'(XLEN);
            hi_q       <= '0;
            lo_q       <= a_mag;
            b_q        <= b_mag;
        end else if (busy_q) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) busy_q <= 1'b0;
            if (!special_q) begin
                if (op_q[2]) begin
                    hi_q <= div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
                    lo_q <= {lo_q[XLEN-2:0], div_ok};
                end else begin
                    hi_q <= mul_sum[XLEN:1];
                    lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
                end
            end
        end
    end

    assign done_o = busy_q && (cnt_q == CNT_W'(1));

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   q_s, r_s, mul_res, div_res;

    assign prod_s   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign q_s      = neg_q ? -lo_q : lo_q;
    assign r_s      = neg_q ? -hi_q : hi_q;
    assign mul_res  = (op_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    assign div_res  = op_q[1] ? r_s : q_s;
    assign result_o = special_q ? spec_res_q : (op_q[2] ? div_res : mul_res);
endmodule

// File: rtl/exe_stage_pipe.sv
// Execute stage with valid/ready on both sides.
//   clk_i, rst_ni            : clock, async active-low reset
//   flush_i                  : kill held instruction, abort MDU
//   in_valid_i / in_ready_o  : decode handshake
//   op_i, src1_i, src2_i     : op code and operands
//   st_data_i, mem_rd_i, mem_wr_i, mem_size_i : memory request fields
//   side_i / side_o          : opaque sideband, registered
//   out_valid_o / out_ready_i: memory-stage handshake
//   result_o, mem_addr_o     : ALU/MDU result (also the address)
//   mem_wdata_o, mem_wmask_o : lane-aligned store data and byte mask
//   mem_wen_o, mem_ren_o, misalign_o : request strobes and alignment fault
// The holding register captures the instruction; the ALU and lane logic work
// combinationally on the held copy, so outputs are stable while stalled.
module exe_stage_pipe
    import exe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int SIDE_W = 64,
    parameter bit MDU_EN = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [5:0]        op_i,
    input  logic [XLEN-1:0]   src1_i,
    input  logic [XLEN-1:0]   src2_i,
    input  logic [XLEN-1:0]   st_data_i,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [1:0]        mem_size_i,
    input  logic [SIDE_W-1:0] side_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   result_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_wmask_o,
    output logic              mem_wen_o,
    output logic              mem_ren_o,
    output logic              misalign_o,
    output logic [SIDE_W-1:0] side_o
);
    localparam int NB     = XLEN / 8;
    localparam int OFFS_W = $clog2(NB);

    typedef struct packed {
        logic [5:0]        op;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic [XLEN-1:0]   st;
        logic              rd;
        logic              wr;
        logic [1:0]        size;
        logic [SIDE_W-1:0] side;
    } hold_t;

    exe_state_e state_q, state_d;
    hold_t      hold_q, hold_d;

    logic accept, out_hs, new_is_mdu, held_is_mdu, mdu_start, mdu_done;
    logic [XLEN-1:0] mdu_res, alu_y;

    assign out_valid_o = (state_q == ST_HOLD);
    assign out_hs      = out_valid_o && out_ready_i;
    assign in_ready_o  = (state_q != ST_MDU_BUSY) && ((state_q == ST_IDLE) || out_hs);
    assign accept      = in_valid_i && in_ready_o && !flush_i;
    assign new_is_mdu  = MDU_EN && is_mdu_op(op_i);
    assign held_is_mdu = MDU_EN && is_mdu_op(hold_q.op);
    assign mdu_start   = accept && new_is_mdu;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept) state_d = new_is_mdu ? ST_MDU_BUSY : ST_HOLD;
            ST_HOLD: begin
                if (accept)      state_d = new_is_mdu ? ST_MDU_BUSY : ST_HOLD;
                else if (out_hs) state_d = ST_IDLE;
            end
            ST_MDU_BUSY: if (mdu_done) state_d = ST_HOLD;
            default:     state_d = ST_IDLE;
        endcase
        if (flush_i) state_d = ST_IDLE;
    end

    always_comb begin
        hold_d = hold_q;
        if (accept) begin
            hold_d.op   = op_i;
            hold_d.src1 = src1_i;
            hold_d.src2 = src2_i;
            hold_d.st   = st_data_i;
            hold_d.rd   = mem_rd_i;
            hold_d.wr   = mem_wr_i;
            hold_d.size = mem_size_i;
            hold_d.side = side_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    exe_alu #(.XLEN(XLEN)) u_alu (
        .op_i (hold_q.op),
        .a_i  (hold_q.src1),
        .b_i  (hold_q.src2),
        .y_o  (alu_y)
    );

    // The MDU samples operands straight from the input port on accept, so it
    // starts iterating in the first busy cycle.
    if (MDU_EN) begin : g_mdu
        exe_mdu #(.XLEN(XLEN)) u_mdu (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .start_i  (mdu_start),
            .abort_i  (flush_i),
            .op_i     (op_i[2:0]),
            .a_i      (src1_i),
            .b_i      (src2_i),
            .done_o   (mdu_done),
            .result_o (mdu_res)
        );
    end else begin : g_no_mdu
        assign mdu_done = 1'b0;
        assign mdu_res  = '0;
    end

    assign result_o   = held_is_mdu ? mdu_res : alu_y;
    assign mem_addr_o = result_o;
    assign side_o     = hold_q.side;

    // byte-lane logic
    logic [OFFS_W-1:0] offs;
    logic [3:0]        align_m;
    logic              misal_raw, req_ok, lane_ok;
    logic [7:0]        smask;

    assign offs      = result_o[OFFS_W-1:0];
    assign align_m   = (4'd1 << hold_q.size) - 4'd1;
    assign misal_raw = |(offs & align_m[OFFS_W-1:0]);
    assign req_ok    = out_valid_o && (hold_q.rd || hold_q.wr);
    assign lane_ok   = req_ok && !misal_raw;
    assign smask     = size_mask(hold_q.size, XLEN);

    assign misalign_o  = req_ok && misal_raw;
    assign mem_wmask_o = lane_ok ? NB'({8'b0, smask} << offs) : '0;
    assign mem_wdata_o = hold_q.st << {offs, 3'b000};
    assign mem_wen_o   = lane_ok && hold_q.wr;
    assign mem_ren_o   = lane_ok && hold_q.rd;
endmodule

// File: tb/tb_exe_stage_pipe.sv
module tb_exe_stage_pipe;
    import exe_pkg::*;

    logic        clk = 1'b0, rst_ni = 1'b1, flush_i = 1'b0;
    logic        in_valid_i = 1'b0, out_ready_i = 1'b1;
    logic [5:0]  op_i = '0;
    logic [31:0] src1_i = '0, src2_i = '0, st_data_i = '0;
    logic        mem_rd_i = 1'b0, mem_wr_i = 1'b0;
    logic [1:0]  mem_size_i = '0;
    logic [63:0] side_i = '0;
    logic        in_ready_o, out_valid_o, mem_wen_o, mem_ren_o, misalign_o;
    logic [31:0] result_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic [63:0] side_o;

    exe_stage_pipe #(.XLEN(32), .SIDE_W(64), .MDU_EN(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .op_i(op_i), .src1_i(src1_i), .src2_i(src2_i), .st_data_i(st_data_i),
        .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i), .mem_size_i(mem_size_i),
        .side_i(side_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wmask_o(mem_wmask_o), .mem_wen_o(mem_wen_o), .mem_ren_o(mem_ren_o),
        .misalign_o(misalign_o), .side_o(side_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_res(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_ADD:    return a + b;
            OP_SUB:    return a - b;
            OP_AND:    return a & b;
            OP_OR:     return a | b;
            OP_XOR:    return a ^ b;
            OP_SLL:    return a << b[4:0];
            OP_SRL:    return a >> b[4:0];
            OP_SRA:    return $unsigned($signed(a) >>> b[4:0]);
            OP_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            OP_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            OP_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            OP_REM:    begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU:   return (b == 0) ? a : a % b;
            default:   return 32'd0;
        endcase
    endfunction

    typedef struct {
        logic [31:0] res, wdata;
        logic [3:0]  mask;
        logic        wen, ren, mis;
        logic [63:0] side;
        int          acc, lat;
    } exp_t;

    function automatic exp_t mk_exp(input int now);
        exp_t e;
        int bytes, offs, m;
        logic memop, sgn_ovf;
        e.res   = ref_res(op_i, src1_i, src2_i);
        offs    = int'(e.res[1:0]);
        bytes   = 1 << mem_size_i;
        memop   = mem_rd_i || mem_wr_i;
        e.mis   = memop && ((offs % bytes) != 0);
        m       = ((1 << bytes) - 1) << offs;
        e.mask  = (memop && !e.mis) ? m[3:0] : 4'b0;
        e.wdata = st_data_i << (8 * offs);
        e.wen   = mem_wr_i && !e.mis;
        e.ren   = mem_rd_i && !e.mis;
        e.side  = side_i;
        e.acc   = now;
        sgn_ovf = (op_i == OP_DIV || op_i == OP_REM) && src1_i == 32'h8000_0000 && src2_i == 32'hFFFF_FFFF;
        if (op_i >= OP_MUL && op_i <= OP_REMU)
            e.lat = (op_i >= OP_DIV && (src2_i == 0 || sgn_ovf)) ? 2 : 33;
        else
            e.lat = 1;
        return e;
    endfunction

    exp_t q[$];
    exp_t cur;
    logic ev, erdy;

    // compare process: one check set per cycle against the model
    always @(negedge clk) begin
        if (!rst_ni) begin
            q.delete();
        end else begin
            ev   = (q.size() > 0) && (cyc >= q[0].acc + q[0].lat);
            erdy = (q.size() == 0) || (ev && out_ready_i);
            chk("out_valid", out_valid_o, ev);
            chk("in_ready", in_ready_o, erdy);
            if (ev) begin
                cur = q[0];
                chk("result", result_o, cur.res);
                chk("mem_addr", mem_addr_o, cur.res);
                chk("wdata", mem_wdata_o, cur.wdata);
                chk("wmask", mem_wmask_o, cur.mask);
                chk("wen", mem_wen_o, cur.wen);
                chk("ren", mem_ren_o, cur.ren);
                chk("misalign", misalign_o, cur.mis);
                chk("side", side_o, cur.side);
            end else begin
                chk("wen_idle", mem_wen_o, 1'b0);
                chk("ren_idle", mem_ren_o, 1'b0);
            end
            if (flush_i) q.delete();
            else begin
                if (ev && out_ready_i) void'(q.pop_front());
                if (in_valid_i && erdy) q.push_back(mk_exp(cyc));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] st, input logic rd, input logic wr, input logic [1:0] sz);
        in_valid_i = 1'b1; op_i = op; src1_i = a; src2_i = b; st_data_i = st;
        mem_rd_i = rd; mem_wr_i = wr; mem_size_i = sz;
        side_i = {$urandom(), $urandom()};
    endtask

    task automatic idle();
        in_valid_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0;
    endtask

    // Issue one op from an empty stage, wait for its result, check latency and value.
    task automatic run_op(input string nm, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] st, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic [31:0] exp_res, input int exp_lat);
        int n;
        drive(op, a, b, st, rd, wr, sz);
        tick(); idle();
        n = 1;
        while (!out_valid_o && n < 100) begin tick(); n++; end
        chk({nm, "_lat"}, 64'(n), 64'(exp_lat));
        chk({nm, "_res"}, result_o, exp_res);
    endtask

    initial begin
        #1 rst_ni = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_in_ready", in_ready_o, 1'b1);
        chk("rst_wen", mem_wen_o, 1'b0);
        chk("rst_ren", mem_ren_o, 1'b0);
        chk("rst_misalign", misalign_o, 1'b0);
        chk("rst_wmask", mem_wmask_o, 4'b0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_wdata", mem_wdata_o, 32'h0);
        chk("rst_side", side_o, 64'h0);
        @(posedge clk); #1 rst_ni = 1'b1;
        tick();

        // back-to-back ALU stream
        drive(OP_ADD, 32'd5, 32'd7, 0, 0, 0, 2);
        @(negedge clk); chk("stream_rdy0", in_ready_o, 1'b1);
        tick(); drive(OP_SUB, 32'd3, 32'd9, 0, 0, 0, 2);
        @(negedge clk); chk("stream_add", result_o, 32'd12); chk("stream_rdy1", in_ready_o, 1'b1);
        tick(); idle();
        @(negedge clk); chk("stream_sub", result_o, 32'hFFFF_FFFA); chk("stream_vld", out_valid_o, 1'b1);
        tick(); tick();

        // store half at 0x1002
        run_op("sth", OP_ADD, 32'h1000, 32'd2, 32'hABCD, 1'b0, 1'b1, 2'd1, 32'h1002, 1);
        chk("sth_addr", mem_addr_o, 32'h1002);
        chk("sth_mask", mem_wmask_o, 4'b1100);
        chk("sth_wdata", mem_wdata_o, 32'hABCD_0000);
        chk("sth_wen", mem_wen_o, 1'b1);
        tick();
        // misaligned word load
        run_op("ldw_mis", OP_ADD, 32'h1000, 32'd1, 32'h0, 1'b1, 1'b0, 2'd2, 32'h1001, 1);
        chk("mis_flag", misalign_o, 1'b1);
        chk("mis_ren", mem_ren_o, 1'b0);
        chk("mis_mask", mem_wmask_o, 4'b0);
        tick();
        // aligned byte store in lane 3
        run_op("stb", OP_ADD, 32'h2000, 32'd3, 32'h5A, 1'b0, 1'b1, 2'd0, 32'h2003, 1);
        chk("stb_mask", mem_wmask_o, 4'b1000);
        chk("stb_wdata", mem_wdata_o, 32'h5A00_0000);
        tick();

        // MDU directed vectors
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 2, 32'hFFFF_FFFD, 33);
        tick();
        run_op("divu0", OP_DIVU, 32'd123, 32'd0, 0, 0, 0, 2, 32'hFFFF_FFFF, 2);
        tick();
        run_op("rem0", OP_REM, 32'd5, 32'd0, 0, 0, 0, 2, 32'd5, 2);
        tick();
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 2, 32'h8000_0000, 2);
        tick();
        run_op("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 2, 32'hFFFF_FFFF, 33);
        tick();
        run_op("remu", OP_REMU, 32'd100, 32'd7, 0, 0, 0, 2, 32'd2, 33);
        tick();
        run_op("mul", OP_MUL, 32'd6, 32'd7, 0, 0, 0, 2, 32'd42, 33);
        tick();
        run_op("mulh", OP_MULH, 32'hFFFF_FFFD, 32'd5, 0, 0, 0, 2, 32'hFFFF_FFFF, 33);
        tick();
        run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 2, 32'hFFFF_FFFE, 33);
        tick();
        run_op("mulhsu", OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 2, 32'h8000_0000, 33);
        tick();
        run_op("sra", OP_SRA, 32'h8000_0000, 32'd4, 0, 0, 0, 2, 32'hF800_0000, 1);
        tick();
        run_op("sltu", OP_SLTU, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 2, 32'd1, 1);
        tick();
        run_op("slt", OP_SLT, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 2, 32'd0, 1);
        tick();

        // backpressure: hold 5 cycles, then accept alongside the handshake
        out_ready_i = 1'b0;
        drive(OP_ADD, 32'd1, 32'd2, 0, 0, 0, 2);
        tick(); idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_result", result_o, 32'd3);
            chk("bp_rdy", in_ready_o, 1'b0);
            tick();
        end
        out_ready_i = 1'b1;
        drive(OP_XOR, 32'hF0, 32'h3C, 0, 0, 0, 2);
        @(negedge clk); chk("bp_release_rdy", in_ready_o, 1'b1);
        tick(); idle();
        @(negedge clk); chk("bp_next", result_o, 32'hCC);
        tick();

        // flush at MDU cycle 10
        drive(OP_MUL, 32'd9, 32'd9, 0, 0, 0, 2);
        tick(); idle();
        repeat (9) tick();
        flush_i = 1'b1;
        tick(); flush_i = 1'b0;
        run_op("post_flush", OP_ADD, 32'd4, 32'd4, 0, 0, 0, 2, 32'd8, 1);
        repeat (40) tick();

        // async reset mid-MDU
        drive(OP_DIVU, 32'd100, 32'd7, 0, 0, 0, 2);
        tick(); idle();
        repeat (5) tick();
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_vld", out_valid_o, 1'b0);
        chk("arst_rdy", in_ready_o, 1'b1);
        chk("arst_res", result_o, 32'h0);
        @(posedge clk); #1 rst_ni = 1'b1;
        repeat (40) tick();
        run_op("post_rst", OP_DIVU, 32'd100, 32'd7, 0, 0, 0, 2, 32'd14, 33);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end
endmodule
